udt_rx_parser: RTL and testbench

Receive-side stage between the UDP/IP stack and the UDT core, running on the UDP clock domain. It consumes the UDP receive stream, discards datagrams not addressed to the UDT port, and splits the 16-byte UDT header into registered sideband fields. The payload is forwarded as a separate AXI-Stream, which the UDT core then buffers into the asynchronous receive FIFO.

---
 rtl/udt_pkg.sv | 20 ++
 rtl/udt_rx_parser.sv | 169 ++++++++++++++++
 tb/tb_udt_rx_parser.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/udt_pkg.sv
// Shared UDT definitions: receive parser states, header geometry and byte-order helper.
package udt_pkg;

   typedef enum logic [2:0] {
      S_HDR0    = 3'd0,
      S_HDR1    = 3'd1,
      S_HDR_OUT = 3'd2,
      S_PAYLOAD = 3'd3,
      S_DROP    = 3'd4
   } rx_state_t;

   localparam int UDT_HDR_BYTES     = 16;
   localparam int UDT_CTRL_FLAG_BIT = 31;

   // Network (big-endian, first byte in bits [7:0]) to host order.
   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

endpackage

// File: rtl/udt_rx_parser.sv
// UDT receive parser: filters the UDP stream on destination port, splits the
// 16-byte UDT header into registered sideband fields and passes the payload
// through combinationally.
module udt_rx_parser
   import udt_pkg::*;
#(
   parameter logic [15:0] PORT      = 16'd10086,
   parameter int          CNT_WIDTH = 32
) (
   input  logic                 udp_clk,
   input  logic                 udp_areset,
   input  logic                 udp_rx_tvalid,
   output logic                 udp_rx_tready,
   input  logic [63:0]          udp_rx_tdata,
   input  logic [7:0]           udp_rx_tkeep,
   input  logic                 udp_rx_tlast,
   input  logic [31:0]          udp_rx_ip_src,
   input  logic [15:0]          udp_rx_port_src,
   input  logic [15:0]          udp_rx_port_dest,
   output logic                 hdr_valid,
   input  logic                 hdr_ready,
   output logic                 hdr_is_ctrl,
   output logic [30:0]          hdr_word0,
   output logic [31:0]          hdr_word1,
   output logic [31:0]          hdr_tstamp,
   output logic [31:0]          hdr_sock_id,
   output logic [31:0]          hdr_peer_ip,
   output logic [15:0]          hdr_peer_port,
   output logic                 hdr_empty,
   output logic                 pay_tvalid,
   input  logic                 pay_tready,
   output logic [63:0]          pay_tdata,
   output logic [7:0]           pay_tkeep,
   output logic                 pay_tlast,
   output logic [CNT_WIDTH-1:0] stat_pkt_cnt,
   output logic [CNT_WIDTH-1:0] stat_drop_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   rx_state_t   state, state_nxt;
   logic        ready_en;
   logic        beat;
   logic        cap0, cap1, drop_inc, pkt_inc;
   logic [31:0] word0_host;

   assign beat       = udp_rx_tvalid && udp_rx_tready;
   assign word0_host = bswap32(udp_rx_tdata[31:0]);

   // Payload is a direct pass-through; only the valid is qualified by state.
   assign pay_tvalid = (state == S_PAYLOAD) && udp_rx_tvalid;
   assign pay_tdata  = udp_rx_tdata;
   assign pay_tkeep  = udp_rx_tkeep;
   assign pay_tlast  = udp_rx_tlast;

   // Input ready: held low until the first clock after reset release, low
   // while a header waits for acceptance, and borrowed from the payload sink.
   always_comb begin
      udp_rx_tready = 1'b0;
      if (ready_en) begin
         case (state)
            S_HDR0, S_HDR1, S_DROP: udp_rx_tready = 1'b1;
            S_PAYLOAD:              udp_rx_tready = pay_tready;
            default:                udp_rx_tready = 1'b0;
         endcase
      end
   end

   // State register and ready enable.
   always_ff @(posedge udp_clk or posedge udp_areset) begin
      if (udp_areset) begin
         state    <= S_HDR0;
         ready_en <= 1'b0;
      end else begin
         state    <= state_nxt;
         ready_en <= 1'b1;
      end
   end

   // Next-state logic with capture and counter strobes.
   always_comb begin
      state_nxt = state;
      cap0      = 1'b0;
      cap1      = 1'b0;
      drop_inc  = 1'b0;
      pkt_inc   = 1'b0;
      case (state)
         S_HDR0: begin
            if (beat) begin
               if ((udp_rx_port_dest != PORT) || (udp_rx_tkeep != 8'hFF) || udp_rx_tlast) begin
                  drop_inc  = 1'b1;
                  state_nxt = udp_rx_tlast ? S_HDR0 : S_DROP;
               end else begin
                  cap0      = 1'b1;
                  state_nxt = S_HDR1;
               end
            end
         end
         S_HDR1: begin
            if (beat) begin
               if (udp_rx_tkeep != 8'hFF) begin
                  drop_inc  = 1'b1;
                  state_nxt = udp_rx_tlast ? S_HDR0 : S_DROP;
               end else begin
                  cap1      = 1'b1;
                  state_nxt = S_HDR_OUT;
               end
            end
         end
         S_HDR_OUT: begin
            if (hdr_valid && hdr_ready) begin
               pkt_inc   = 1'b1;
               state_nxt = hdr_empty ? S_HDR0 : S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (beat && udp_rx_tlast) state_nxt = S_HDR0;
         end
         S_DROP: begin
            if (beat && udp_rx_tlast) state_nxt = S_HDR0;
         end
         default: state_nxt = S_HDR0;
      endcase
   end

   // Header capture registers; fields only move in the header states, so they
   // hold steady for as long as hdr_valid is up.
   always_ff @(posedge udp_clk or posedge udp_areset) begin
      if (udp_areset) begin
         hdr_valid     <= 1'b0;
         hdr_is_ctrl   <= 1'b0;
         hdr_word0     <= '0;
         hdr_word1     <= '0;
         hdr_tstamp    <= '0;
         hdr_sock_id   <= '0;
         hdr_peer_ip   <= '0;
         hdr_peer_port <= '0;
         hdr_empty     <= 1'b0;
      end else begin
         if (cap0) begin
            hdr_is_ctrl   <= word0_host[UDT_CTRL_FLAG_BIT];
            hdr_word0     <= word0_host[30:0];
            hdr_word1     <= bswap32(udp_rx_tdata[63:32]);
            hdr_peer_ip   <= udp_rx_ip_src;
            hdr_peer_port <= udp_rx_port_src;
         end
         if (cap1) begin
            hdr_tstamp  <= bswap32(udp_rx_tdata[31:0]);
            hdr_sock_id <= bswap32(udp_rx_tdata[63:32]);
            hdr_empty   <= udp_rx_tlast;
            hdr_valid   <= 1'b1;
         end else if (pkt_inc) begin
            hdr_valid <= 1'b0;
         end
      end
   end

   // Statistics counters, free-running and wrapping.
   always_ff @(posedge udp_clk or posedge udp_areset) begin
      if (udp_areset) begin
         stat_pkt_cnt  <= '0;
         stat_drop_cnt <= '0;
      end else begin
         if (pkt_inc)  stat_pkt_cnt  <= stat_pkt_cnt + CNT_ONE;
         if (drop_inc) stat_drop_cnt <= stat_drop_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_udt_rx_parser.sv
// Directed testbench for udt_rx_parser.
module tb_udt_rx_parser;
   import udt_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        udp_rx_tvalid = 1'b0;
   logic        udp_rx_tready;
   logic [63:0] udp_rx_tdata = '0;
   logic [7:0]  udp_rx_tkeep = '0;
   logic        udp_rx_tlast = 1'b0;
   logic [31:0] udp_rx_ip_src = 32'hC0A80001;
   logic [15:0] udp_rx_port_src = 16'd5000;
   logic [15:0] udp_rx_port_dest = 16'd10086;
   logic        hdr_valid;
   logic        hdr_ready = 1'b1;
   logic        hdr_is_ctrl;
   logic [30:0] hdr_word0;
   logic [31:0] hdr_word1, hdr_tstamp, hdr_sock_id, hdr_peer_ip;
   logic [15:0] hdr_peer_port;
   logic        hdr_empty;
   logic        pay_tvalid;
   logic        pay_tready = 1'b1;
   logic [63:0] pay_tdata;
   logic [7:0]  pay_tkeep;
   logic        pay_tlast;
   logic [31:0] stat_pkt_cnt, stat_drop_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int stalls = 0;
   int hv_seen = 0;
   bit tog = 1'b0;
   logic [72:0] pay_q[$];

   udt_rx_parser #(.PORT(16'd10086), .CNT_WIDTH(32)) dut (
      .udp_clk(clk), .udp_areset(rst),
      .udp_rx_tvalid(udp_rx_tvalid), .udp_rx_tready(udp_rx_tready),
      .udp_rx_tdata(udp_rx_tdata), .udp_rx_tkeep(udp_rx_tkeep), .udp_rx_tlast(udp_rx_tlast),
      .udp_rx_ip_src(udp_rx_ip_src), .udp_rx_port_src(udp_rx_port_src),
      .udp_rx_port_dest(udp_rx_port_dest),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_is_ctrl(hdr_is_ctrl),
      .hdr_word0(hdr_word0), .hdr_word1(hdr_word1), .hdr_tstamp(hdr_tstamp),
      .hdr_sock_id(hdr_sock_id), .hdr_peer_ip(hdr_peer_ip), .hdr_peer_port(hdr_peer_port),
      .hdr_empty(hdr_empty),
      .pay_tvalid(pay_tvalid), .pay_tready(pay_tready), .pay_tdata(pay_tdata),
      .pay_tkeep(pay_tkeep), .pay_tlast(pay_tlast),
      .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt)
   );

   always #5 clk = ~clk;

   // Observe the cycle just before each rising edge.
   always begin
      @(negedge clk);
      #4;
      if (pay_tvalid && pay_tready) pay_q.push_back({pay_tlast, pay_tkeep, pay_tdata});
      if (hdr_valid) hv_seen++;
   end

   // Present one input beat and hold it until it is accepted (bounded).
   task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l,
                       input logic [15:0] pd);
      bit done;
      done = 1'b0;
      @(negedge clk);
      udp_rx_tvalid    = 1'b1;
      udp_rx_tdata     = d;
      udp_rx_tkeep     = k;
      udp_rx_tlast     = l;
      udp_rx_port_dest = pd;
      for (int i = 0; i < 50 && !done; i++) begin
         if (tog) pay_tready = ~pay_tready;
         #4;
         if (udp_rx_tready) begin
            @(posedge clk);
            done = 1'b1;
         end else begin
            stalls++;
            @(negedge clk);
         end
      end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: beat %h not accepted, required acceptance within 50 cycles", d);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      udp_rx_tvalid = 1'b0;
      udp_rx_tlast  = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (udp_rx_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b want 0", udp_rx_tready); end
      n_cmp++; if (hdr_valid !== 1'b0) begin n_err++; $display("FAIL rst_hdr_valid: got %b want 0", hdr_valid); end
      n_cmp++; if (pay_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_pay_tvalid: got %b want 0", pay_tvalid); end
      n_cmp++; if (hdr_word0 !== 31'h0 || hdr_sock_id !== 32'h0) begin n_err++; $display("FAIL rst_hdr_fields: got %h/%h want 0/0", hdr_word0, hdr_sock_id); end
      n_cmp++; if (stat_pkt_cnt !== 32'd0 || stat_drop_cnt !== 32'd0) begin n_err++; $display("FAIL rst_counters: got %0d/%0d want 0/0", stat_pkt_cnt, stat_drop_cnt); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (udp_rx_tready !== 1'b0) begin n_err++; $display("FAIL rst_release_tready: got %b want 0", udp_rx_tready); end
      @(negedge clk);
      n_cmp++; if (udp_rx_tready !== 1'b1) begin n_err++; $display("FAIL ready_en_tready: got %b want 1", udp_rx_tready); end
   endtask

   task automatic test_data();
      int q0;
      q0 = pay_q.size();
      send(64'h44332211_05000000, 8'hFF, 1'b0, 16'd10086);
      send(64'hBEBAFECA_0D0C0B0A, 8'hFF, 1'b0, 16'd10086);
      @(negedge clk);
      n_cmp++; if (hdr_valid !== 1'b1) begin n_err++; $display("FAIL data_hdr_valid: got %b want 1", hdr_valid); end
      n_cmp++; if (hdr_is_ctrl !== 1'b0 || hdr_word0 !== 31'd5) begin n_err++; $display("FAIL data_word0: got ctrl=%b w0=%h want 0/5", hdr_is_ctrl, hdr_word0); end
      n_cmp++; if (hdr_word1 !== 32'h11223344) begin n_err++; $display("FAIL data_word1: got %h want 11223344", hdr_word1); end
      n_cmp++; if (hdr_tstamp !== 32'h0A0B0C0D || hdr_sock_id !== 32'hCAFEBABE) begin n_err++; $display("FAIL data_ts_sock: got %h/%h want 0a0b0c0d/cafebabe", hdr_tstamp, hdr_sock_id); end
      n_cmp++; if (hdr_peer_ip !== 32'hC0A80001 || hdr_peer_port !== 16'd5000) begin n_err++; $display("FAIL data_peer: got %h/%0d want c0a80001/5000", hdr_peer_ip, hdr_peer_port); end
      n_cmp++; if (hdr_empty !== 1'b0) begin n_err++; $display("FAIL data_empty: got %b want 0", hdr_empty); end
      n_cmp++; if (udp_rx_tready !== 1'b0) begin n_err++; $display("FAIL data_hdr_out_tready: got %b want 0", udp_rx_tready); end
      send(64'h01234567_89ABCDEF, 8'hFF, 1'b0, 16'd10086);
      send(64'h00000000_DEADBEEF, 8'h0F, 1'b1, 16'd10086);
      idle();
      n_cmp++; if (pay_q.size() !== q0 + 2) begin n_err++; $display("FAIL data_pay_count: got %0d want %0d", pay_q.size(), q0 + 2); end
      else begin
         n_cmp++; if (pay_q[q0] !== {1'b0, 8'hFF, 64'h01234567_89ABCDEF}) begin n_err++; $display("FAIL data_pay0: got %h want 0ff0123456789abcdef", pay_q[q0]); end
         n_cmp++; if (pay_q[q0+1] !== {1'b1, 8'h0F, 64'h00000000_DEADBEEF}) begin n_err++; $display("FAIL data_pay1: got %h want 10f00000000deadbeef", pay_q[q0+1]); end
      end
      n_cmp++; if (stat_pkt_cnt !== 32'd1 || stat_drop_cnt !== 32'd0) begin n_err++; $display("FAIL data_counters: got %0d/%0d want 1/0", stat_pkt_cnt, stat_drop_cnt); end
   endtask

   task automatic test_ctrl();
      int q0;
      q0 = pay_q.size();
      send(64'h00000000_00000280, 8'hFF, 1'b0, 16'd10086);
      send(64'h07000000_64000000, 8'hFF, 1'b1, 16'd10086);
      @(negedge clk);
      n_cmp++; if (hdr_valid !== 1'b1 || hdr_is_ctrl !== 1'b1) begin n_err++; $display("FAIL ctrl_flag: got v=%b ctrl=%b want 1/1", hdr_valid, hdr_is_ctrl); end
      n_cmp++; if (hdr_word0 !== 31'h00020000) begin n_err++; $display("FAIL ctrl_word0: got %h want 00020000", hdr_word0); end
      n_cmp++; if (hdr_empty !== 1'b1) begin n_err++; $display("FAIL ctrl_empty: got %b want 1", hdr_empty); end
      n_cmp++; if (hdr_tstamp !== 32'h00000064 || hdr_sock_id !== 32'h00000007) begin n_err++; $display("FAIL ctrl_ts_sock: got %h/%h want 64/7", hdr_tstamp, hdr_sock_id); end
      send(64'h44332211_06000000, 8'hFF, 1'b0, 16'd10086);
      send(64'hBEBAFECA_0D0C0B0A, 8'hFF, 1'b1, 16'd10086);
      @(negedge clk);
      n_cmp++; if (hdr_valid !== 1'b1 || hdr_is_ctrl !== 1'b0 || hdr_word0 !== 31'd6) begin n_err++; $display("FAIL ctrl_next_hdr: got v=%b ctrl=%b w0=%h want 1/0/6", hdr_valid, hdr_is_ctrl, hdr_word0); end
      idle();
      n_cmp++; if (pay_q.size() !== q0) begin n_err++; $display("FAIL ctrl_no_payload: got %0d beats want 0", pay_q.size() - q0); end
      n_cmp++; if (stat_pkt_cnt !== 32'd3) begin n_err++; $display("FAIL ctrl_pkt_cnt: got %0d want 3", stat_pkt_cnt); end
   endtask

   task automatic test_drop_port();
      int q0, h0, s0;
      q0 = pay_q.size(); h0 = hv_seen; s0 = stalls;
      send(64'h44332211_07000000, 8'hFF, 1'b0, 16'd10087);
      send(64'hBEBAFECA_0D0C0B0A, 8'hFF, 1'b0, 16'd10087);
      send(64'h01234567_89ABCDEF, 8'hFF, 1'b1, 16'd10087);
      idle();
      n_cmp++; if (stalls !== s0) begin n_err++; $display("FAIL drop_tready: got %0d stall cycles want 0", stalls - s0); end
      n_cmp++; if (hv_seen !== h0 || pay_q.size() !== q0) begin n_err++; $display("FAIL drop_outputs: got hdr=%0d pay=%0d want 0/0", hv_seen - h0, pay_q.size() - q0); end
      n_cmp++; if (stat_drop_cnt !== 32'd1) begin n_err++; $display("FAIL drop_cnt: got %0d want 1", stat_drop_cnt); end
   endtask

   task automatic test_runt();
      int h0;
      h0 = hv_seen;
      send(64'h44332211_08000000, 8'hFF, 1'b1, 16'd10086);
      send(64'h44332211_08000000, 8'hFF, 1'b0, 16'd10086);
      send(64'h0000FECA_0D0C0B0A, 8'h3F, 1'b1, 16'd10086);
      idle();
      n_cmp++; if (stat_drop_cnt !== 32'd3) begin n_err++; $display("FAIL runt_drop_cnt: got %0d want 3", stat_drop_cnt); end
      n_cmp++; if (hv_seen !== h0) begin n_err++; $display("FAIL runt_no_hdr: got %0d hdr cycles want 0", hv_seen - h0); end
      n_cmp++; if (stat_pkt_cnt !== 32'd3) begin n_err++; $display("FAIL runt_pkt_cnt: got %0d want 3", stat_pkt_cnt); end
   endtask

   task automatic test_backpressure();
      int q0;
      q0 = pay_q.size();
      hdr_ready = 1'b0;
      send(64'h44332211_09000000, 8'hFF, 1'b0, 16'd10086);
      send(64'hBEBAFECA_0D0C0B0A, 8'hFF, 1'b0, 16'd10086);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (hdr_valid !== 1'b1 || hdr_word0 !== 31'd9 || hdr_sock_id !== 32'hCAFEBABE || udp_rx_tready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold%0d: got v=%b w0=%h sock=%h rdy=%b want 1/9/cafebabe/0", i, hdr_valid, hdr_word0, hdr_sock_id, udp_rx_tready);
         end
      end
      @(negedge clk);
      hdr_ready = 1'b1;
      tog = 1'b1;
      send(64'h11111111_11111111, 8'hFF, 1'b0, 16'd10086);
      send(64'h22222222_22222222, 8'hFF, 1'b0, 16'd10086);
      send(64'h00000000_33333333, 8'h0F, 1'b1, 16'd10086);
      tog = 1'b0;
      idle();
      pay_tready = 1'b1;
      n_cmp++; if (pay_q.size() !== q0 + 3) begin n_err++; $display("FAIL bp_pay_count: got %0d want %0d", pay_q.size(), q0 + 3); end
      else begin
         n_cmp++; if (pay_q[q0] !== {1'b0, 8'hFF, 64'h11111111_11111111}) begin n_err++; $display("FAIL bp_pay0: got %h", pay_q[q0]); end
         n_cmp++; if (pay_q[q0+1] !== {1'b0, 8'hFF, 64'h22222222_22222222}) begin n_err++; $display("FAIL bp_pay1: got %h", pay_q[q0+1]); end
         n_cmp++; if (pay_q[q0+2] !== {1'b1, 8'h0F, 64'h00000000_33333333}) begin n_err++; $display("FAIL bp_pay2: got %h", pay_q[q0+2]); end
      end
      n_cmp++; if (stat_pkt_cnt !== 32'd4) begin n_err++; $display("FAIL bp_pkt_cnt: got %0d want 4", stat_pkt_cnt); end
   endtask

   task automatic test_reset_mid();
      send(64'h44332211_0A000000, 8'hFF, 1'b0, 16'd10086);
      send(64'hBEBAFECA_0D0C0B0A, 8'hFF, 1'b0, 16'd10086);
      send(64'h44444444_44444444, 8'hFF, 1'b0, 16'd10086);
      @(negedge clk);
      udp_rx_tdata = 64'h55555555_55555555;
      udp_rx_tkeep = 8'hFF;
      udp_rx_tlast = 1'b1;
      rst = 1'b1;
      #1;
      n_cmp++; if (udp_rx_tready !== 1'b0 || pay_tvalid !== 1'b0 || hdr_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctrl: got rdy=%b pv=%b hv=%b want 0/0/0", udp_rx_tready, pay_tvalid, hdr_valid); end
      n_cmp++; if (hdr_word0 !== 31'h0 || hdr_tstamp !== 32'h0 || hdr_peer_ip !== 32'h0) begin n_err++; $display("FAIL mid_rst_fields: got %h/%h/%h want 0/0/0", hdr_word0, hdr_tstamp, hdr_peer_ip); end
      n_cmp++; if (stat_pkt_cnt !== 32'd0 || stat_drop_cnt !== 32'd0) begin n_err++; $display("FAIL mid_rst_counters: got %0d/%0d want 0/0", stat_pkt_cnt, stat_drop_cnt); end
      udp_rx_tvalid = 1'b0;
      udp_rx_tlast  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(64'h44332211_21000000, 8'hFF, 1'b0, 16'd10086);
      send(64'hBEBAFECA_0D0C0B0A, 8'hFF, 1'b1, 16'd10086);
      @(negedge clk);
      n_cmp++; if (hdr_valid !== 1'b1 || hdr_word0 !== 31'h21 || hdr_empty !== 1'b1) begin n_err++; $display("FAIL mid_clean_hdr: got v=%b w0=%h e=%b want 1/21/1", hdr_valid, hdr_word0, hdr_empty); end
      idle();
      n_cmp++; if (stat_pkt_cnt !== 32'd1 || stat_drop_cnt !== 32'd0) begin n_err++; $display("FAIL mid_counters: got %0d/%0d want 1/0", stat_pkt_cnt, stat_drop_cnt); end
   endtask

   initial begin
      test_reset();
      test_data();
      test_ctrl();
      test_drop_port();
      test_runt();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
